vedic_dot_acc: RTL and testbench
================================

VEDIC_DOT_ACC -- requirements
Module: vedic_dot_acc

Interface
REQ-001 Parameter VEC_LEN, default 8, number of operand pairs per dot product (legal range 2..256).
REQ-002 Parameter ACC_W, default 20, accumulator and result width in bits (minimum 16).
REQ-003 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, operand pair a/b valid.
REQ-006 Port in_ready, output, 1, block accepts a pair this cycle.
REQ-007 Port a, input, 8, unsigned multiplicand.
REQ-008 Port b, input, 8, unsigned multiplier.
REQ-009 Port out_valid, output, 1, dot-product result available.
REQ-010 Port out_ready, input, 1, downstream consumes the result this cycle.
REQ-011 Port out_data, output, ACC_W, unsigned sum of VEC_LEN products.
REQ-012 Port out_ovf, output, 1, the sum exceeded 2^ACC_W-1 during this vector.

Function
REQ-013 A pair is accepted on a rising edge where in_valid and in_ready are both 1; the block ignores a/b at all other times.
REQ-014 Product stage: on accept, register p_q <= a*b (16-bit, exact) and p_v <= 1; otherwise p_v <= 0.
REQ-015 Accumulate stage: on each edge with p_v=1, acc <= acc + zero-extended p_q; a carry beyond ACC_W bits sets the sticky ovf flag.
REQ-016 FSM states: FILL, DRAIN, HOLD; reset state is FILL.
REQ-017 FILL: in_ready=1, out_valid=0; an accepted pair increments cnt; an accept with cnt==VEC_LEN-1 moves to DRAIN.
REQ-018 DRAIN: in_ready=0, out_valid=0; the last product is added; the FSM moves unconditionally to HOLD on the next edge.
REQ-019 HOLD: in_ready=0, out_valid=1, out_data=acc, out_ovf=ovf; all three stay stable until out_ready=1.
REQ-020 HOLD with out_ready=1: on that edge, clear acc, ovf and cnt and go to FILL; in_ready returns to 1 in the next cycle.
REQ-021 Latency: out_valid is 1 in the second cycle after the cycle in which the last pair of a vector is accepted.
REQ-022 Throughput: one pair per cycle in FILL; gaps in in_valid stall cnt without loss.
REQ-023 out_data and out_ovf are 0 whenever out_valid=0.

Reset
REQ-024 On rst=1 at a rising edge: state<=FILL; cnt, acc, ovf, p_q and p_v <= 0; the partial vector in flight is discarded.
REQ-025 Outputs during and after reset: in_ready=1, out_valid=0, out_data=0, out_ovf=0; rst has priority over every accept or handoff on the same edge.

Configuration
REQ-026 Macro VEDIC_DOT_SAT_EN defined: on overflow, acc clamps to 2^ACC_W-1 and holds there for the rest of the vector; ovf is set.
REQ-027 Macro VEDIC_DOT_SAT_EN undefined: acc wraps modulo 2^ACC_W; ovf is still set.

Structure
REQ-028 Package vedic_pkg holds the constants MUL_W=16 and OPD_W=8 and the FSM state encodings FILL/DRAIN/HOLD.
REQ-029 The product stage instantiates the existing vedic_8X8 sub-module (a, b -> c) combinationally ahead of the p_q register; no other sub-module is used.

Verification
REQ-030 VEC_LEN=4, ACC_W=20, back-to-back pairs a={1,2,3,4}, b=2, out_ready=1 -> out_data=20, out_ovf=0, out_valid high exactly 2 cycles after the 4th accept.
REQ-031 VEC_LEN=4, ACC_W=20, all pairs a=b=255 -> out_data=260100, out_ovf=0.
REQ-032 VEC_LEN=8, ACC_W=18, all pairs a=b=255 -> with VEDIC_DOT_SAT_EN out_data=262143, out_ovf=1; without it out_data=258056, out_ovf=1.
REQ-033 Backpressure: result ready, out_ready held 0 for 5 cycles -> out_valid=1, in_ready=0 and out_data stable throughout; a single handoff occurs; the next vector sum is correct and independent of the previous one.
REQ-034 Reset mid-vector: accept 2 pairs (a=b=10), assert rst for 1 cycle, then send 4 pairs a=b=1 with VEC_LEN=4 -> out_data=4.
REQ-035 in_valid toggled every other cycle with all a=b=0 -> out_data=0, out_ovf=0, and no extra or missing accepts (cnt matches VEC_LEN).

Source files
------------

// File: rtl/vedic_pkg.sv
// vedic_pkg: shared widths and FSM state encodings for the vedic dot-product accumulator
package vedic_pkg;
  localparam int MUL_W = 16;
  localparam int OPD_W = 8;
  typedef enum logic [1:0] {FILL = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/vedic_8X8.sv
// vedic_8X8: combinational 8x8 unsigned Urdhva-Tiryagbhyam multiplier built from 4x4 and 2x2 blocks
module vedic_8X8
  import vedic_pkg::*;
(
  input  logic [OPD_W-1:0] a,
  input  logic [OPD_W-1:0] b,
  output logic [MUL_W-1:0] c
);
  function automatic logic [3:0] v2(input logic [1:0] x, input logic [1:0] y);
    return {3'b0, x[0] & y[0]} + {2'b0, x[1] & y[0], 1'b0} + {2'b0, x[0] & y[1], 1'b0} + {1'b0, x[1] & y[1], 2'b0};
  endfunction
  function automatic logic [7:0] v4(input logic [3:0] x, input logic [3:0] y);
    return {4'b0, v2(x[1:0], y[1:0])} + {2'b0, v2(x[1:0], y[3:2]), 2'b0} + {2'b0, v2(x[3:2], y[1:0]), 2'b0} + {v2(x[3:2], y[3:2]), 4'b0};
  endfunction
  assign c = {8'b0, v4(a[3:0], b[3:0])} + {4'b0, v4(a[3:0], b[7:4]), 4'b0} + {4'b0, v4(a[7:4], b[3:0]), 4'b0} + {v4(a[7:4], b[7:4]), 8'b0};
endmodule

// File: rtl/vedic_dot_acc.sv
// vedic_dot_acc: streaming VEC_LEN-term dot product with registered vedic products and FILL/DRAIN/HOLD handoff.
// Define VEDIC_DOT_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module vedic_dot_acc
  import vedic_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPD_W-1:0] a,
  input  logic [OPD_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);
  localparam int CW = $clog2(VEC_LEN);
  localparam int SW = ACC_W + 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [MUL_W-1:0] prod, p_q;
  logic p_v, ovf, accept, handoff;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [SW-1:0] sum;
  vedic_8X8 u_mul (.a(a), .b(b), .c(prod));
  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;
  assign sum     = {1'b0, acc} + SW'(p_q);
`ifdef VEDIC_DOT_SAT_EN
  // once clamped, the accumulator stays pinned for the rest of the vector
  assign acc_nx = (ovf | sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
`else
  assign acc_nx = sum[ACC_W-1:0];
`endif
  always_ff @(posedge clk)
    if (rst) state <= FILL;
    else state <= nxt;
  always_comb
    nxt = state == FILL  ? ((accept && cnt == CW'(VEC_LEN - 1)) ? DRAIN : FILL) :
          state == DRAIN ? HOLD :
          (out_ready ? FILL : HOLD);
  always_comb begin
    in_ready  = state == FILL;
    out_valid = state == HOLD;
    out_data  = out_valid ? acc : '0;
    out_ovf   = out_valid & ovf;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      ovf <= 1'b0;
      p_q <= '0;
      p_v <= 1'b0;
    end else begin
      p_v <= accept;
      if (accept) p_q <= prod;
      if (handoff) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else begin
        if (p_v) begin
          acc <= acc_nx;
          ovf <= ovf | sum[ACC_W];
        end
        if (accept) cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_vedic_dot_acc.sv
// tb_vedic_dot_acc: table-driven and randomized checks of vedic_dot_acc (VEC_LEN=4/ACC_W=20 and VEC_LEN=8/ACC_W=18)
module tb_vedic_dot_acc;
  logic clk = 0;
  logic rst;
  logic [1:0] in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [7:0] av[2], bv[2];
  logic [19:0] od0;
  logic [17:0] od1;
  int tests = 0, fails = 0;
  int qa[$], qb[$];
  always #5 clk = ~clk;
  vedic_dot_acc #(.VEC_LEN(4), .ACC_W(20)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(av[0]), .b(bv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0), .out_ovf(out_ovf[0]));
  vedic_dot_acc #(.VEC_LEN(8), .ACC_W(18)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(av[1]), .b(bv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1), .out_ovf(out_ovf[1]));
  typedef struct {int s; int a0; int inc; int bv; int gap; int stall; int ed; int eo;} vec_t;
`ifdef VEDIC_DOT_SAT_EN
  localparam int ED_SAT = 262143;
`else
  localparam int ED_SAT = 258056;
`endif
  function automatic int vlen(input int s);
    return s != 0 ? 8 : 4;
  endfunction
  function automatic logic [31:0] odat(input int s);
    return s != 0 ? 32'(od1) : 32'(od0);
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // dot product from the queued pairs, then wrap or clamp to the instance width
  task automatic model(input int s, output int d, output int o);
    longint total = 0;
    longint lim = (s != 0) ? (64'd1 << 18) : (64'd1 << 20);
    foreach (qa[i]) total += qa[i] * qb[i];
    o = int'(total >= lim);
`ifdef VEDIC_DOT_SAT_EN
    d = int'(o != 0 ? lim - 1 : total);
`else
    d = int'(total % lim);
`endif
  endtask
  task automatic run_vec(input int s, input int gap, input int stall, input int ed, input int eo, input string nm);
    int i = 0, cyc = 0;
    logic [31:0] held;
    logic idle;
    while (i < vlen(s) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      idle = gap == 1 ? (cyc % 2 == 0) : gap == 2 ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (idle) begin
        in_valid[s] = 0;
        av[s] = 8'hff;
        bv[s] = 8'hff;
      end else begin
        in_valid[s] = 1;
        av[s] = 8'(qa[i]);
        bv[s] = 8'(qb[i]);
        if (in_ready[s]) i++;
      end
    end
    if (i < vlen(s)) chk({nm, "_accept_timeout"}, 32'(i), 32'(vlen(s)));
    @(negedge clk);
    in_valid[s] = 0;
    chk({nm, "_drain_valid"}, 32'(out_valid[s]), 0);
    chk({nm, "_drain_ready"}, 32'(in_ready[s]), 0);
    @(negedge clk);
    chk({nm, "_latency_valid"}, 32'(out_valid[s]), 1);
    chk({nm, "_data"}, odat(s), 32'(ed));
    chk({nm, "_ovf"}, 32'(out_ovf[s]), 32'(eo));
    held = odat(s);
    repeat (stall) begin
      @(negedge clk);
      chk({nm, "_stall_valid"}, 32'(out_valid[s]), 1);
      chk({nm, "_stall_ready"}, 32'(in_ready[s]), 0);
      chk({nm, "_stall_data"}, odat(s), held);
    end
    out_ready[s] = 1;
    @(negedge clk);
    out_ready[s] = 0;
    chk({nm, "_post_valid"}, 32'(out_valid[s]), 0);
    chk({nm, "_post_ready"}, 32'(in_ready[s]), 1);
    chk({nm, "_post_data"}, odat(s), 0);
    chk({nm, "_post_ovf"}, 32'(out_ovf[s]), 0);
    qa.delete();
    qb.delete();
  endtask
  initial begin
    vec_t tbl[6];
    int d, o;
    tbl[0] = '{0, 1, 1, 2, 0, 0, 20, 0};
    tbl[1] = '{0, 255, 0, 255, 0, 5, 260100, 0};
    tbl[2] = '{1, 255, 0, 255, 0, 2, ED_SAT, 1};
    tbl[3] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[4] = '{0, 5, 3, 7, 0, 1, 266, 0};
    tbl[5] = '{1, 1, 1, 1, 2, 3, 36, 0};
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    av = '{8'd0, 8'd0};
    bv = '{8'd0, 8'd0};
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_in_ready", 32'(in_ready[s]), 1);
      chk("rst_out_valid", 32'(out_valid[s]), 0);
      chk("rst_out_data", odat(s), 0);
      chk("rst_out_ovf", 32'(out_ovf[s]), 0);
    end
    rst = 0;
    @(negedge clk);
    chk("after_rst_in_ready", 32'(in_ready[0]), 1);
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < vlen(tbl[t].s); i++) begin
        qa.push_back(tbl[t].a0 + i * tbl[t].inc);
        qb.push_back(tbl[t].bv);
      end
      run_vec(tbl[t].s, tbl[t].gap, tbl[t].stall, tbl[t].ed, tbl[t].eo, $sformatf("tbl%0d", t));
    end
    // partial vector discarded by reset
    in_valid[0] = 1;
    av[0] = 10;
    bv[0] = 10;
    repeat (2) @(negedge clk);
    in_valid[0] = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst_in_ready", 32'(in_ready[0]), 1);
    chk("midrst_out_valid", 32'(out_valid[0]), 0);
    chk("midrst_data", odat(0), 0);
    repeat (4) begin
      qa.push_back(1);
      qb.push_back(1);
    end
    run_vec(0, 0, 0, 4, 0, "midrst_vec");
    // reset wins over a handoff on the same edge
    in_valid[0] = 1;
    av[0] = 3;
    bv[0] = 3;
    repeat (4) @(negedge clk);
    in_valid[0] = 0;
    repeat (2) @(negedge clk);
    chk("hold_before_rst", 32'(out_valid[0]), 1);
    chk("hold_before_rst_data", odat(0), 36);
    rst = 1;
    out_ready[0] = 1;
    @(negedge clk);
    rst = 0;
    out_ready[0] = 0;
    chk("rst_vs_handoff_valid", 32'(out_valid[0]), 0);
    chk("rst_vs_handoff_ready", 32'(in_ready[0]), 1);
    for (int r = 0; r < 12; r++) begin
      int s = r % 2;
      for (int i = 0; i < vlen(s); i++) begin
        qa.push_back(r > 8 ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255));
        qb.push_back(r > 8 ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255));
      end
      model(s, d, o);
      run_vec(s, 2, $urandom_range(0, 3), d, o, $sformatf("rnd%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
